seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 123 ++++++++++++
 tb/tb_seg7_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - samples a multiplexed 7-segment display and assembles 4-digit frames
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [6:0]  seg7,
    input  logic [3:0]  seg7_nSel,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  bad,
    output logic        overrun
);

    localparam logic [10:0] IDLE = 11'h7FF;
    localparam logic [7:0]  CAP  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]  SAT  = 8'(STABLE_CYCLES);

    logic [1:0]  rst_sync;
    logic        run;
    logic [10:0] s1, s2, prev;
    logic [7:0]  cnt, cnt_next;
    logic [3:0]  sel;
    logic        one_hot;
    logic        capture;
    logic        complete;
    logic [3:0]  seen;
    logic [15:0] sh_val;
    logic [3:0]  sh_blank, sh_bad;
    logic [3:0]  dec_nib;
    logic        dec_blank, dec_bad;

    // Deassertion is retimed so the front end never starts mid-cycle after release.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign sel      = ~s2[10:7];
    assign one_hot  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign complete = (seen == 4'hF);

    always_comb begin
        cnt_next = 8'd0;
        if (s2 == prev) cnt_next = (cnt == SAT) ? cnt : cnt + 8'd1;
    end

    // Fires in the single cycle the dwell count first reaches STABLE_CYCLES-1.
    assign capture = run && one_hot && (cnt_next == CAP);

    always_comb begin
        dec_nib   = 4'd0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (s2[6:0])
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1011000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b0100111: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1        <= IDLE;
            s2        <= IDLE;
            prev      <= IDLE;
            cnt       <= 8'd0;
            seen      <= 4'd0;
            sh_val    <= 16'd0;
            sh_blank  <= 4'd0;
            sh_bad    <= 4'd0;
            value     <= 16'd0;
            blank     <= 4'd0;
            bad       <= 4'd0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (run) begin
            s1   <= {seg7_nSel, seg7};
            s2   <= s1;
            prev <= s2;
            cnt  <= cnt_next;
            seen <= (complete ? 4'd0 : seen) | (capture ? sel : 4'd0);
            if (capture) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel[k]) begin
                        sh_val[4*k +: 4] <= dec_nib;
                        sh_blank[k]      <= dec_blank;
                        sh_bad[k]        <= dec_bad;
                    end
                end
            end
            if (complete && (!out_valid || out_ready)) begin
                value     <= sh_val;
                blank     <= sh_blank;
                bad       <= sh_bad;
                out_valid <= 1'b1;
            end else if (complete) begin
                overrun   <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - randomized and directed bench for seg7_capture against a frame model
module tb_seg7_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [6:0]  seg7 = 7'h7F;
    logic [3:0]  seg7_nSel = 4'hF;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] value;
    logic [3:0]  blank, bad;
    logic        overrun;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .nReset(nReset), .seg7(seg7), .seg7_nSel(seg7_nSel),
        .out_ready(out_ready), .out_valid(out_valid), .value(value),
        .blank(blank), .bad(bad), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  bl;
        logic [3:0]  bd;
    } frame_t;

    int checks = 0;
    int passes = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [15:0] m_val = 16'd0;
    logic [3:0]  m_blank = 4'd0, m_bad = 4'd0, m_seen = 4'd0;
    frame_t      exp_q[$];
    frame_t      got_q[$];

    always @(negedge clk) begin
        if (nReset && out_valid && out_ready) begin
            frame_t f;
            f.v = value; f.bl = blank; f.bd = bad;
            got_q.push_back(f);
        end
    end

    // A dwell of n cycles on a one-hot select captures iff n >= S.
    function automatic void model_apply(input logic [3:0] nsel, input logic [6:0] seg, input int n);
        logic [3:0] s;
        logic [3:0] nib;
        logic       bl, bd;
        frame_t     f;
        s = ~nsel;
        if (n < S || $countones(s) != 1) return;
        nib = 4'd0;
        bl  = (seg == 7'h7F);
        bd  = !bl;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == seg) begin
                nib = 4'(i);
                bd  = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
                m_val[4*k +: 4] = nib;
                m_blank[k] = bl;
                m_bad[k]   = bd;
            end
        end
        m_seen |= s;
        if (m_seen == 4'hF) begin
            f.v = m_val; f.bl = m_blank; f.bd = m_bad;
            exp_q.push_back(f);
            m_seen = 4'd0;
        end
    endfunction

    function automatic logic [3:0] dsel(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    task automatic dwell(input logic [3:0] nsel, input logic [6:0] seg, input int n);
        seg7_nSel = nsel;
        seg7 = seg;
        repeat (n) @(posedge clk);
        #1;
        model_apply(nsel, seg, n);
    endtask

    task automatic drain_scoreboard(input string name);
        frame_t g, e;
        dwell(4'hF, 7'h7F, S + 8);
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s frame_count got %0d want %0d", name, got_q.size(), exp_q.size());
        else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.v !== e.v || g.bl !== e.bl || g.bd !== e.bd)
                $display("FAIL %s frame got %h/%b/%b want %h/%b/%b", name, g.v, g.bl, g.bd, e.v, e.bl, e.bd);
            else passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, value, blank, bad, overrun} !== 26'd0)
            $display("FAIL reset_hold got %b/%h/%b/%b/%b want all 0", out_valid, value, blank, bad, overrun);
        else passes++;
        nReset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passes++;
        checks++;
        if (value !== 16'd0) $display("FAIL reset_value got %h want 0", value); else passes++;
    endtask

    task automatic test_basic;
        dwell(dsel(0), 7'b0001110, 8);
        dwell(dsel(1), 7'b0100111, 8);
        dwell(dsel(2), 7'b1000000, 8);
        dwell(dsel(3), 7'b0010010, 8);
        checks++;
        if (got_q.size() != 1) $display("FAIL basic_pulses got %0d want 1", got_q.size()); else passes++;
        drain_scoreboard("basic");
        checks++;
        if (value !== 16'h50CF) $display("FAIL basic_value got %h want 50cf", value); else passes++;
        checks++;
        if (blank !== 4'd0 || bad !== 4'd0) $display("FAIL basic_flags got %b/%b want 0000/0000", blank, bad); else passes++;
    endtask

    task automatic test_latency;
        int n;
        dwell(dsel(0), seg_tab[3], 8);
        dwell(dsel(1), seg_tab[7], 8);
        dwell(dsel(2), seg_tab[9], 8);
        seg7_nSel = dsel(3);
        seg7 = seg_tab[2];
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != S + 3) $display("FAIL latency got %0d edges want %0d", n, S + 3); else passes++;
        @(posedge clk);
        #1;
        model_apply(dsel(3), seg_tab[2], 8);
        drain_scoreboard("latency");
    endtask

    task automatic test_short_dwell;
        dwell(dsel(0), seg_tab[1], 8);
        dwell(dsel(1), seg_tab[4], 8);
        dwell(dsel(2), seg_tab[6], S - 1);
        dwell(dsel(3), seg_tab[8], 8);
        dwell(4'hF, 7'h7F, S + 8);
        checks++;
        if (got_q.size() != 0) $display("FAIL short_dwell_frames got %0d want 0", got_q.size()); else passes++;
        drain_scoreboard("short_dwell_none");
        dwell(dsel(2), seg_tab[6], 8);
        drain_scoreboard("short_dwell_full");
    endtask

    task automatic test_blank_bad;
        dwell(dsel(0), seg_tab[8], 8);
        dwell(dsel(1), 7'b1111111, 8);
        dwell(dsel(2), seg_tab[1], 8);
        dwell(dsel(3), 7'b1010101, 8);
        drain_scoreboard("blank_bad");
        checks++;
        if (blank !== 4'b0010) $display("FAIL blank_bits got %b want 0010", blank); else passes++;
        checks++;
        if (bad !== 4'b1000) $display("FAIL bad_bits got %b want 1000", bad); else passes++;
        checks++;
        if (value[7:4] !== 4'd0 || value[15:12] !== 4'd0)
            $display("FAIL blank_bad_nibbles got %h want x0x0 pattern 0_1_0_8", value);
        else passes++;
        checks++;
        if (value !== 16'h0108) $display("FAIL blank_bad_value got %h want 0108", value); else passes++;
    endtask

    task automatic test_overrun;
        logic [15:0] first;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) dwell(dsel(k), seg_tab[k + 4], 8);
        for (int k = 0; k < 4; k++) dwell(dsel(k), seg_tab[k + 10], 8);
        first = exp_q[0].v;
        dwell(4'hF, 7'h7F, 6);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL overrun_valid got %b want 1", out_valid); else passes++;
        checks++;
        if (value !== first) $display("FAIL overrun_hold got %h want %h", value, first); else passes++;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun); else passes++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL overrun_accept got %b want 0", out_valid); else passes++;
        checks++;
        if (overrun !== 1'b1 || value !== first)
            $display("FAIL overrun_sticky got %b/%h want 1/%h", overrun, value, first);
        else passes++;
        exp_q.delete(1);
        drain_scoreboard("overrun");
    endtask

    task automatic test_no_select;
        dwell(dsel(0), seg_tab[2], 8);
        dwell(dsel(1), seg_tab[3], 8);
        dwell(4'b0011, seg_tab[5], 20);
        dwell(4'b1111, seg_tab[6], 20);
        checks++;
        if (got_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL no_select got %0d frames valid %b want 0/0", got_q.size(), out_valid);
        else passes++;
        dwell(dsel(2), seg_tab[7], 8);
        dwell(dsel(3), seg_tab[9], 8);
        drain_scoreboard("no_select");
    endtask

    task automatic test_reset_mid;
        dwell(dsel(0), seg_tab[12], 8);
        dwell(dsel(1), seg_tab[13], 8);
        #2;
        nReset = 1'b0;
        #1;
        checks++;
        if ({out_valid, value, blank, bad, overrun} !== 26'd0)
            $display("FAIL reset_mid got %b/%h/%b/%b/%b want all 0", out_valid, value, blank, bad, overrun);
        else passes++;
        m_seen = 4'd0; m_val = 16'd0; m_blank = 4'd0; m_bad = 4'd0;
        @(posedge clk);
        #1;
        nReset = 1'b1;
        dwell(4'hF, 7'h7F, 6);
        dwell(dsel(2), seg_tab[14], 8);
        dwell(dsel(3), seg_tab[15], 8);
        drain_scoreboard("reset_mid_partial");
        for (int k = 0; k < 4; k++) dwell(dsel(k), seg_tab[k * 3], 8);
        drain_scoreboard("reset_mid_full");
    endtask

    task automatic test_random;
        logic [3:0] ns, last;
        logic [6:0] sg;
        int         r;
        last = 4'hF;
        for (int i = 0; i < 80; i++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 8) ns = dsel($urandom_range(0, 3));
                else       ns = 4'($urandom_range(0, 15));
            end while (ns == last);
            r = $urandom_range(0, 9);
            if (r < 7)       sg = seg_tab[$urandom_range(0, 15)];
            else if (r == 7) sg = 7'h7F;
            else             sg = 7'($urandom_range(0, 127));
            dwell(ns, sg, $urandom_range(2, 9));
            last = ns;
        end
        drain_scoreboard("random");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_latency;
        test_short_dwell;
        test_blank_bad;
        test_overrun;
        test_no_select;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
